twilight_tune_sequencer: RTL and testbench
==========================================

# twilight_tune_sequencer

Melody sequencer and tone generator feeding the audio path of the twilight-cat top level. It steps through a fixed note table, holds each note for a frame-counted duration paced by the VGA frame tick, and emits a square wave on the PWM pin plus the amplifier shutdown control. It also emits a beat pulse so the video side can animate in time with the tune.

## Interface
- CLK_HZ, 100_000_000, system clock frequency; note half-periods are derived from it at elaboration.
- NOTE_COUNT, 16, table depth; must be a power of two, so the step index wraps naturally.
- DIV_W, 18, tone divider width; must hold CLK_HZ/(2*262).

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- enable  in  1  level; high = play, low = stop and rewind
- mute  in  1  level; forces aud_pwm low, sequencing continues
- frame_tick  in  1  one-cycle pulse per video frame (vsync start)
- aud_pwm  out  1  square-wave tone
- aud_sd  out  1  amplifier enable, high while playing
- playing  out  1  high in any state except IDLE
- beat  out  1  one-cycle pulse at each note start
- step  out  log2(NOTE_COUNT)  index of the current table entry

## Operation
- Table entry: 4-bit pitch code, 4-bit duration in frames. Pitch 0 = rest; 1..15 map to 262,294,330,349,392,440,494,523,587,659,698,784,880,988,1047 Hz. Duration 0 means 16 frames.
- Half-period for pitch p is floor(CLK_HZ/(2*hz[p])) clocks, computed at elaboration.
- FSM states: IDLE, LOAD, PLAY, GAP.
  - IDLE: outputs low, step=0. enable=1 -> LOAD.
  - LOAD: one cycle. Latches the entry at step. Loads the divider with half-period-1 and clears aud_pwm. -> PLAY.
  - PLAY: divider counts down; at 0 it toggles aud_pwm and reloads. A rest holds aud_pwm at 0. Frame counter increments on frame_tick. On the tick that reaches the duration -> GAP.
  - GAP: aud_pwm=0 (articulation silence). Next frame_tick -> LOAD with step+1, wrapping NOTE_COUNT-1 -> 0.
- enable=0 in any non-IDLE state: go to IDLE next cycle, step=0, aud_pwm=0, aud_sd=0. enable wins over a simultaneous frame_tick.
- aud_sd = playing, registered.
- mute gates only aud_pwm. The divider keeps running, so unmuting mid-note resumes the phase.
- frame_tick is ignored in IDLE and LOAD.

## Timing
- Reset values: aud_pwm=0, aud_sd=0, playing=0, beat=0, step=0, state IDLE, counters 0.
- All outputs are registered.
- enable rises at cycle N: LOAD at N+1. PLAY, playing=1, aud_sd=1 and beat=1 at N+2.
- beat is high only in the first PLAY cycle of each note, including rests.
- First aud_pwm rise comes half-period clocks after PLAY entry. Tone period = 2*half-period clocks exactly.
- A note of duration d leaves PLAY the cycle after the d-th frame_tick seen in PLAY. It spends exactly one frame in GAP.
- Reset asserted mid-note: all outputs reach reset values at the next edge.

## Structure
- twilight_pkg holds:
  - the state enum;
  - the note frequency table;
  - the tune table TUNE[NOTE_COUNT] as {pitch, dur} constants;
  - a constant function hz_to_half(clk_hz, hz).
- TUNE entries 0..2 are fixed as {6,2}, {0,1}, {13,3} for verification. Entry 15 = {8,1}.
- Sub-module tune_tone_div: loadable down-counter plus toggle flop, with load, run and half inputs and an out output. FSM, frame counter and step logic stay in the top module.

## Test plan
- Reset and idle: hold rst_n=0, then release with enable=0 for 1000 cycles -> all outputs 0, step=0.
- Start and tone at CLK_HZ=100_000: raise enable -> beat at +2 cycles. aud_pwm period 226 clocks (half 113, 440 Hz) during entry 0. Entry 0 ends after the 2nd frame_tick; one GAP frame follows; step=1.
- Rest and high note: entry 1 -> beat pulses, aud_pwm stays 0 for 1 frame. Entry 2 -> half-period 56 clocks for 3 frames.
- Wrap: run 16 entries -> step goes 15 -> 0. Entry 15 plays half-period 95 clocks for 1 frame.
- Stop and mute: deassert enable mid-PLAY together with frame_tick -> IDLE next cycle, step=0, aud_sd=0. With mute=1 during PLAY -> aud_pwm=0 while step and beat still advance.
- Reset mid-note: assert rst_n=0 during PLAY of entry 2 -> reset values at the next edge. Restart begins at entry 0.

Source files
------------

// File: rtl/twilight_tune_sequencer_pkg.sv
// rtl/twilight_tune_sequencer_pkg.sv - states, note frequencies and tune table for the melody sequencer
package twilight_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_PLAY = 2'd2;
    localparam state_t ST_GAP  = 2'd3;

    typedef struct packed {
        logic [3:0] pitch;
        logic [3:0] dur;
    } note_t;

    // Pitch code 0 is a rest and has no frequency.
    localparam int NOTE_HZ [16] = '{0, 262, 294, 330, 349, 392, 440, 494,
                                    523, 587, 659, 698, 784, 880, 988, 1047};

    // Each entry is {pitch, dur}; a duration of 0 plays for 16 frames.
    localparam logic [7:0] TUNE [16] = '{8'h62, 8'h01, 8'hD3, 8'hA1, 8'h91, 8'h82, 8'h01, 8'h50,
                                         8'h31, 8'h51, 8'h61, 8'hC1, 8'hF1, 8'hE1, 8'h01, 8'h81};

    function automatic int hz_to_half(input int clk_hz, input int hz);
        return (hz == 0) ? 0 : clk_hz / (2 * hz);
    endfunction

endpackage

// File: rtl/twilight_tune_sequencer_if.sv
// rtl/twilight_tune_sequencer_if.sv - control and audio/beat signals of the tune sequencer
interface twilight_tune_sequencer_if #(
    parameter int NOTE_COUNT = 16
);
    localparam int STEP_W = $clog2(NOTE_COUNT);

    logic              enable;
    logic              mute;
    logic              frame_tick;
    logic              aud_pwm;
    logic              aud_sd;
    logic              playing;
    logic              beat;
    logic [STEP_W-1:0] step;

    modport master (
        output enable, mute, frame_tick,
        input  aud_pwm, aud_sd, playing, beat, step
    );

    modport slave (
        input  enable, mute, frame_tick,
        output aud_pwm, aud_sd, playing, beat, step
    );

endinterface

// File: rtl/twilight_tune_sequencer_tone_div.sv
// rtl/twilight_tune_sequencer_tone_div.sv - loadable half-period down-counter with toggle flop
module tune_tone_div #(
    parameter int DIV_W = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] half,
    output logic             out,
    output logic             out_next
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_next;
    logic [DIV_W-1:0] half_q;

    // out_next lets the owner register a gated copy of the tone without adding a cycle of lag.
    always_comb begin
        cnt_next = cnt;
        out_next = out;
        if (load) begin
            cnt_next = half - 1'b1;
            out_next = 1'b0;
        end else if (run) begin
            if (cnt == '0) begin
                cnt_next = half_q - 1'b1;
                out_next = ~out;
            end else begin
                cnt_next = cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            half_q <= '0;
            out    <= 1'b0;
        end else begin
            cnt <= cnt_next;
            out <= out_next;
            if (load) begin
                half_q <= half;
            end
        end
    end

endmodule

// File: rtl/twilight_tune_sequencer.sv
// rtl/twilight_tune_sequencer.sv - frame-paced melody sequencer driving a square-wave tone and beat pulse
module twilight_tune_sequencer
    import twilight_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int NOTE_COUNT = 16,
    parameter int DIV_W      = 18
) (
    input logic                       clk,
    input logic                       rst_n,
    twilight_tune_sequencer_if.slave  bus
);

    localparam int STEP_W = $clog2(NOTE_COUNT);

    state_t            state;
    state_t            state_nxt;
    logic [STEP_W-1:0] step_q;
    logic [3:0]        pitch_q;
    logic [4:0]        dur_q;
    logic [4:0]        frames;
    logic              beat_q;
    logic              playing_q;
    logic              aud_pwm_q;
    logic              tone;
    logic              tone_next;
    note_t             cur;
    logic [DIV_W-1:0]  half_tab [16];

    for (genvar i = 0; i < 16; i++) begin : g_half
        assign half_tab[i] = DIV_W'(hz_to_half(CLK_HZ, NOTE_HZ[i]));
    end

    assign cur = note_t'(TUNE[step_q]);

    // Dropping enable takes priority over any frame_tick in the same cycle.
    always_comb begin
        state_nxt = state;
        if (state != ST_IDLE && !bus.enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (bus.enable) state_nxt = ST_LOAD;
                ST_LOAD: state_nxt = ST_PLAY;
                ST_PLAY: if (bus.frame_tick && (frames + 5'd1) == dur_q) state_nxt = ST_GAP;
                ST_GAP:  if (bus.frame_tick) state_nxt = ST_LOAD;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    tune_tone_div #(.DIV_W(DIV_W)) u_tone_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ST_LOAD),
        .run      ((state == ST_PLAY) && (pitch_q != 4'd0)),
        .half     (half_tab[cur.pitch]),
        .out      (tone),
        .out_next (tone_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            step_q    <= '0;
            pitch_q   <= '0;
            dur_q     <= '0;
            frames    <= '0;
            beat_q    <= 1'b0;
            playing_q <= 1'b0;
            aud_pwm_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            // playing stays up through the LOAD between notes but not the one right after IDLE.
            playing_q <= (state != ST_IDLE) && (state_nxt != ST_IDLE);
            beat_q    <= (state == ST_LOAD) && (state_nxt == ST_PLAY);
            aud_pwm_q <= (state_nxt == ST_PLAY) && !bus.mute && tone_next;

            if (state_nxt == ST_IDLE) begin
                step_q <= '0;
            end else if (state == ST_GAP && state_nxt == ST_LOAD) begin
                step_q <= step_q + 1'b1;
            end

            if (state == ST_LOAD) begin
                pitch_q <= cur.pitch;
                dur_q   <= {cur.dur == 4'd0, cur.dur};
                frames  <= '0;
            end else if (state == ST_PLAY && bus.frame_tick) begin
                frames <= frames + 5'd1;
            end
        end
    end

    assign bus.aud_pwm = aud_pwm_q;
    assign bus.aud_sd  = playing_q;
    assign bus.playing = playing_q;
    assign bus.beat    = beat_q;
    assign bus.step    = step_q;

endmodule

// File: tb/tb_twilight_tune_sequencer.sv
// tb/tb_twilight_tune_sequencer.sv - self-checking bench for twilight_tune_sequencer
module tb_twilight_tune_sequencer;

    localparam int CLK_HZ = 100_000;
    localparam int FRAME  = 600;
    localparam int HZ [16] = '{0, 262, 294, 330, 349, 392, 440, 494,
                               523, 587, 659, 698, 784, 880, 988, 1047};
    localparam logic [7:0] TB_TUNE [16] = '{8'h62, 8'h01, 8'hD3, 8'hA1, 8'h91, 8'h82, 8'h01, 8'h50,
                                            8'h31, 8'h51, 8'h61, 8'hC1, 8'hF1, 8'hE1, 8'h01, 8'h81};
    localparam int P_IDLE = 0, P_LOAD = 1, P_PLAY = 2, P_GAP = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic auto_tick;
    logic man_tick;
    bit   ticks_on;
    int   checks = 0;
    int   errors = 0;

    twilight_tune_sequencer_if #(.NOTE_COUNT(16)) bus ();

    assign bus.frame_tick = auto_tick | man_tick;

    twilight_tune_sequencer #(
        .CLK_HZ     (CLK_HZ),
        .NOTE_COUNT (16),
        .DIV_W      (18)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int outs();
        return int'({bus.aud_pwm, bus.aud_sd, bus.playing, bus.beat, bus.step});
    endfunction

    function automatic int pitch_of(input int s);
        logic [7:0] e;
        e = TB_TUNE[s];
        return int'(e[7:4]);
    endfunction

    function automatic int dur_of(input int s);
        logic [7:0] e;
        e = TB_TUNE[s];
        return (e[3:0] == 4'd0) ? 16 : int'(e[3:0]);
    endfunction

    function automatic int half_of(input int p);
        return (p == 0) ? 0 : CLK_HZ / (2 * HZ[p]);
    endfunction

    // Model: phase of the tune, current note index, cycles since the note started sounding.
    int m_ph = P_IDLE, m_step = 0, m_t = 0, m_frames = 0;
    bit m_started = 0, m_mq = 0;

    function automatic int expected();
        int pl, bt, pwm, p;
        p   = pitch_of(m_step);
        pl  = (m_ph == P_PLAY || m_ph == P_GAP || (m_ph == P_LOAD && m_started)) ? 1 : 0;
        bt  = (m_ph == P_PLAY && m_t == 0) ? 1 : 0;
        pwm = 0;
        if (m_ph == P_PLAY && p != 0 && !m_mq) pwm = (m_t / half_of(p)) % 2;
        return (pwm << 7) | (pl << 6) | (pl << 5) | (bt << 4) | m_step;
    endfunction

    always @(posedge clk) begin
        logic rs, en, fr, mu;
        rs = rst_n; en = bus.enable; fr = bus.frame_tick; mu = bus.mute;
        if (!rs) begin
            m_ph = P_IDLE; m_step = 0; m_t = 0; m_frames = 0; m_started = 0; m_mq = 0;
        end else begin
            m_mq = mu;
            if (m_ph != P_IDLE && !en) begin
                m_ph = P_IDLE; m_step = 0;
            end else begin
                case (m_ph)
                    P_IDLE: if (en) begin m_ph = P_LOAD; m_started = 0; end
                    P_LOAD: begin m_ph = P_PLAY; m_t = 0; m_frames = 0; m_started = 1; end
                    P_PLAY: begin
                        m_t++;
                        if (fr) begin
                            m_frames++;
                            if (m_frames == dur_of(m_step)) m_ph = P_GAP;
                        end
                    end
                    default: if (fr) begin m_ph = P_LOAD; m_step = (m_step + 1) % 16; end
                endcase
            end
        end
        #1;
        chk("cycle_outputs", outs(), expected());
    end

    initial begin
        int fcnt;
        auto_tick = 1'b0;
        fcnt = 0;
        forever begin
            @(negedge clk);
            if (!ticks_on) begin
                fcnt = 0; auto_tick = 1'b0;
            end else if (fcnt == FRAME - 1) begin
                fcnt = 0; auto_tick = 1'b1;
            end else begin
                fcnt++; auto_tick = 1'b0;
            end
        end
    end

    task automatic wait_beat(input int budget, output int highs);
        int c;
        c = 0; highs = 0;
        do begin
            @(negedge clk);
            c++;
            if (bus.aud_pwm === 1'b1) highs++;
        end while (bus.beat !== 1'b1 && c < budget);
        chk("beat_arrives", int'(bus.beat), 1);
    endtask

    // Called on the beat cycle; measures first rise delay and rise-to-rise period.
    task automatic measure(input string nm, input int h);
        int c, p;
        bit seen0;
        c = 0;
        while (bus.aud_pwm !== 1'b1 && c < 3000) begin @(negedge clk); c++; end
        chk({nm, "_first_rise"}, c, h);
        p = 0; seen0 = 0;
        while (!(seen0 && bus.aud_pwm === 1'b1) && p < 3000) begin
            @(negedge clk);
            p++;
            if (bus.aud_pwm === 1'b0) seen0 = 1;
        end
        chk({nm, "_period"}, p, 2 * h);
    endtask

    initial begin
        int h;
        rst_n = 1'b0; bus.enable = 1'b0; bus.mute = 1'b0; ticks_on = 0; man_tick = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        chk("idle_outputs", outs(), 0);

        bus.enable = 1'b1; ticks_on = 1;
        @(negedge clk);
        chk("load_beat", int'(bus.beat), 0);
        chk("load_playing", int'(bus.playing), 0);
        @(negedge clk);
        chk("play_beat", int'(bus.beat), 1);
        chk("play_playing", int'(bus.playing), 1);
        chk("play_aud_sd", int'(bus.aud_sd), 1);
        chk("play_step", int'(bus.step), 0);
        measure("e0", 113);

        wait_beat(20000, h);
        chk("e1_step", int'(bus.step), 1);
        wait_beat(20000, h);
        chk("rest_pwm_highs", h, 0);
        chk("e2_step", int'(bus.step), 2);
        measure("e2", 56);

        for (int k = 0; k < 16 && bus.step != 4'd15; k++) wait_beat(20000, h);
        chk("reach_step15", int'(bus.step), 15);
        measure("e15", 95);
        wait_beat(20000, h);
        chk("wrap_step", int'(bus.step), 0);

        bus.mute = 1'b1;
        wait_beat(20000, h);
        chk("mute_pwm_highs", h, 0);
        chk("mute_step", int'(bus.step), 1);
        wait_beat(20000, h);
        chk("mute_step2", int'(bus.step), 2);
        bus.mute = 1'b0;

        repeat (60) @(negedge clk);
        chk("pre_reset_pwm", int'(bus.aud_pwm), 1);
        rst_n = 1'b0; ticks_on = 0;
        @(negedge clk);
        chk("reset_outputs", outs(), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1; ticks_on = 1;
        wait_beat(20000, h);
        chk("restart_step", int'(bus.step), 0);

        wait_beat(20000, h);
        wait_beat(20000, h);
        chk("prestop_step", int'(bus.step), 2);
        repeat (30) @(negedge clk);
        ticks_on = 0; man_tick = 1'b1; bus.enable = 1'b0;
        @(negedge clk);
        man_tick = 1'b0;
        chk("stop_playing", int'(bus.playing), 0);
        chk("stop_aud_sd", int'(bus.aud_sd), 0);
        chk("stop_step", int'(bus.step), 0);
        repeat (50) @(negedge clk);
        chk("stopped_outputs", outs(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
